// File: rtl/dram_arb_pkg.sv
// Shared types and constants for the three-client DRAM slot arbiter.
package dram_arb_pkg;

  localparam int ADDR_W       = 21;
  localparam int DATA_W       = 16;
  localparam int RFSH_MAX_DEF = 31;

  // Client that owns a DRAM slot (or the pending read return).
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VID  = 2'd1,
    OWN_DMA  = 2'd2,
    OWN_CPU  = 2'd3
  } own_e;

endpackage

// File: rtl/dram_arb_if.sv
// Client, phase-strobe and controller signals of the DRAM slot arbiter.
// The arbiter uses the slave modport; clients and controller side use master.
interface dram_arb_if;
  import dram_arb_pkg::*;

  logic              c0;
  logic              c1;
  logic              c2;
  logic              c3;

  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_ack;
  logic              vid_rdstrb;

  logic              dma_req;
  logic [ADDR_W-1:0] dma_addr;
  logic              dma_rnw;
  logic [1:0]        dma_bsel;
  logic [DATA_W-1:0] dma_wrdata;
  logic              dma_ack;
  logic              dma_rdstrb;

  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_rnw;
  logic [1:0]        cpu_bsel;
  logic [DATA_W-1:0] cpu_wrdata;
  logic              cpu_ack;
  logic              cpu_rdstrb;

  logic [DATA_W-1:0] rddata;
  logic [DATA_W-1:0] dram_rd;
  logic              dram_req;
  logic              dram_rnw;
  logic [ADDR_W-1:0] dram_addr;
  logic [1:0]        dram_bsel;
  logic [DATA_W-1:0] dram_wrdata;

  modport slave (
    input  c0, c1, c2, c3,
    input  vid_req, vid_addr,
    input  dma_req, dma_addr, dma_rnw, dma_bsel, dma_wrdata,
    input  cpu_req, cpu_addr, cpu_rnw, cpu_bsel, cpu_wrdata,
    input  dram_rd,
    output vid_ack, vid_rdstrb, dma_ack, dma_rdstrb, cpu_ack, cpu_rdstrb,
    output rddata, dram_req, dram_rnw, dram_addr, dram_bsel, dram_wrdata
  );

  modport master (
    output c0, c1, c2, c3,
    output vid_req, vid_addr,
    output dma_req, dma_addr, dma_rnw, dma_bsel, dma_wrdata,
    output cpu_req, cpu_addr, cpu_rnw, cpu_bsel, cpu_wrdata,
    output dram_rd,
    input  vid_ack, vid_rdstrb, dma_ack, dma_rdstrb, cpu_ack, cpu_rdstrb,
    input  rddata, dram_req, dram_rnw, dram_addr, dram_bsel, dram_wrdata
  );

endinterface

// File: rtl/dram_rfsh_guard.sv
// Refresh guard: counts consecutive granted slots and forces one idle slot
// once RFSH_MAX grants have been issued back to back.
module dram_rfsh_guard
  import dram_arb_pkg::*;
#(
  parameter int RFSH_MAX = RFSH_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic c2,
  input  logic granted,
  output logic force_idle
);

  localparam logic [7:0] MAX_C = 8'(RFSH_MAX);

  logic [7:0] cnt_r;
  logic [7:0] cnt_nxt_s;

  // Next count: saturating increment on a grant, clear on an idle slot.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (granted) begin
      if (cnt_r == MAX_C) begin
        cnt_nxt_s = MAX_C;
      end else begin
        cnt_nxt_s = cnt_r + 8'd1;
      end
    end else begin
      cnt_nxt_s = 8'd0;
    end
  end

  // Counter and registered force flag advance only at decision edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r      <= 8'd0;
      force_idle <= 1'b0;
    end else if (c2) begin
      cnt_r      <= cnt_nxt_s;
      force_idle <= (cnt_nxt_s == MAX_C);
    end else begin
      cnt_r      <= cnt_r;
      force_idle <= force_idle;
    end
  end

endmodule

// File: rtl/dram_arb.sv
// Three-client DRAM slot arbiter: one grant per 4-phase DRAM cycle, decided
// at the c2 edge. Video has fixed priority, DMA/CPU share round-robin, and
// the refresh guard can force an idle slot. Read data of the previous granted
// read slot is captured at the same c2 edge.
module dram_arb
  import dram_arb_pkg::*;
#(
  parameter int RFSH_MAX = RFSH_MAX_DEF
) (
  input logic       clk,
  input logic       rst,
  dram_arb_if.slave bus
);

  own_e grant_s;
  own_e owner_r;       // client of the previous granted read slot
  logic ptr_r;         // round-robin preference: 0 = DMA, 1 = CPU
  logic force_idle_s;
  logic granted_s;
  logic unused_phase_s;

  // Only c2 matters to the arbiter; the other strobes are carried for the controller.
  assign unused_phase_s = bus.c0 ^ bus.c1 ^ bus.c3;

  // Slot winner: forced idle, then video, then DMA/CPU by pointer.
  always_comb begin
    grant_s = OWN_NONE;
    if (force_idle_s) begin
      grant_s = OWN_NONE;
    end else if (bus.vid_req) begin
      grant_s = OWN_VID;
    end else if (bus.dma_req && bus.cpu_req) begin
      grant_s = ptr_r ? OWN_CPU : OWN_DMA;
    end else if (bus.dma_req) begin
      grant_s = OWN_DMA;
    end else if (bus.cpu_req) begin
      grant_s = OWN_CPU;
    end else begin
      grant_s = OWN_NONE;
    end
  end

  assign granted_s = (grant_s != OWN_NONE);

  dram_rfsh_guard #(
    .RFSH_MAX (RFSH_MAX)
  ) u_guard (
    .clk        (clk),
    .rst        (rst),
    .c2         (bus.c2),
    .granted    (granted_s),
    .force_idle (force_idle_s)
  );

  // Slot register: grant outputs, ack/strobe pulses and read capture at c2.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.vid_ack     <= 1'b0;
      bus.dma_ack     <= 1'b0;
      bus.cpu_ack     <= 1'b0;
      bus.vid_rdstrb  <= 1'b0;
      bus.dma_rdstrb  <= 1'b0;
      bus.cpu_rdstrb  <= 1'b0;
      bus.rddata      <= 16'h0000;
      bus.dram_req    <= 1'b0;
      bus.dram_rnw    <= 1'b0;
      bus.dram_addr   <= 21'h000000;
      bus.dram_bsel   <= 2'b00;
      bus.dram_wrdata <= 16'h0000;
      owner_r         <= OWN_NONE;
      ptr_r           <= 1'b0;
    end else if (bus.c2) begin
      bus.vid_ack    <= (grant_s == OWN_VID);
      bus.dma_ack    <= (grant_s == OWN_DMA);
      bus.cpu_ack    <= (grant_s == OWN_CPU);
      bus.vid_rdstrb <= (owner_r == OWN_VID);
      bus.dma_rdstrb <= (owner_r == OWN_DMA);
      bus.cpu_rdstrb <= (owner_r == OWN_CPU);
      if (owner_r != OWN_NONE) begin
        bus.rddata <= bus.dram_rd;
      end else begin
        bus.rddata <= bus.rddata;
      end
      case (grant_s)
        OWN_VID: begin
          bus.dram_req  <= 1'b1;
          bus.dram_addr <= bus.vid_addr;
          bus.dram_rnw  <= 1'b1;
          bus.dram_bsel <= 2'b11;
          owner_r       <= OWN_VID;
        end
        OWN_DMA: begin
          bus.dram_req    <= 1'b1;
          bus.dram_addr   <= bus.dma_addr;
          bus.dram_rnw    <= bus.dma_rnw;
          bus.dram_bsel   <= bus.dma_bsel;
          bus.dram_wrdata <= bus.dma_wrdata;
          owner_r         <= bus.dma_rnw ? OWN_DMA : OWN_NONE;
          ptr_r           <= 1'b1;
        end
        OWN_CPU: begin
          bus.dram_req    <= 1'b1;
          bus.dram_addr   <= bus.cpu_addr;
          bus.dram_rnw    <= bus.cpu_rnw;
          bus.dram_bsel   <= bus.cpu_bsel;
          bus.dram_wrdata <= bus.cpu_wrdata;
          owner_r         <= bus.cpu_rnw ? OWN_CPU : OWN_NONE;
          ptr_r           <= 1'b0;
        end
        default: begin
          bus.dram_req <= 1'b0;
          owner_r      <= OWN_NONE;
        end
      endcase
    end else begin
      bus.vid_ack    <= 1'b0;
      bus.dma_ack    <= 1'b0;
      bus.cpu_ack    <= 1'b0;
      bus.vid_rdstrb <= 1'b0;
      bus.dma_rdstrb <= 1'b0;
      bus.cpu_rdstrb <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dram_arb.sv
// Self-checking bench for dram_arb: two instances (RFSH_MAX 31 and 3) share
// one stimulus stream and are compared every clock against a slot-level model.
`timescale 1ns/1ps
module tb_dram_arb;
  import dram_arb_pkg::*;

  typedef struct packed {
    logic        vid_req;  logic [20:0] vid_addr;
    logic        dma_req;  logic [20:0] dma_addr; logic dma_rnw; logic [1:0] dma_bsel; logic [15:0] dma_wrdata;
    logic        cpu_req;  logic [20:0] cpu_addr; logic cpu_rnw; logic [1:0] cpu_bsel; logic [15:0] cpu_wrdata;
    logic [15:0] dram_rd;
  } ins_t;

  typedef struct packed {
    logic        vid_ack, dma_ack, cpu_ack;
    logic        vid_rdstrb, dma_rdstrb, cpu_rdstrb;
    logic [15:0] rddata;
    logic        dram_req, dram_rnw;
    logic [20:0] dram_addr;
    logic [1:0]  dram_bsel;
    logic [15:0] dram_wrdata;
  } outs_t;

  typedef struct {
    ins_t        in;
    logic [2:0]  ack;   // {vid,dma,cpu}
    logic [2:0]  strb;  // {vid,dma,cpu}
    logic [15:0] rdd;
    logic [40:0] busv;  // {req,rnw,addr,bsel,wrdata}
  } vec_t;

  logic clk;
  logic rst;
  logic [1:0] phase;
  ins_t in_v;
  outs_t act [2];

  int n_pass = 0;
  int n_tot  = 0;

  // model state per instance
  int    rmax_m [2] = '{31, 3};
  int    cnt_m  [2];   // grants since last idle slot
  int    last_m [2];   // last round-robin client served (2 = DMA, 3 = CPU)
  int    own_m  [2];   // owner of pending read return (0 none, 1 vid, 2 dma, 3 cpu)
  int    gr_m   [2];   // grant of the latest decision
  outs_t exp_o  [2];

  dram_arb_if bus [2] ();

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int RM = (g == 0) ? 31 : 3;
    assign bus[g].c0         = (phase == 2'd0);
    assign bus[g].c1         = (phase == 2'd1);
    assign bus[g].c2         = (phase == 2'd2);
    assign bus[g].c3         = (phase == 2'd3);
    assign bus[g].vid_req    = in_v.vid_req;
    assign bus[g].vid_addr   = in_v.vid_addr;
    assign bus[g].dma_req    = in_v.dma_req;
    assign bus[g].dma_addr   = in_v.dma_addr;
    assign bus[g].dma_rnw    = in_v.dma_rnw;
    assign bus[g].dma_bsel   = in_v.dma_bsel;
    assign bus[g].dma_wrdata = in_v.dma_wrdata;
    assign bus[g].cpu_req    = in_v.cpu_req;
    assign bus[g].cpu_addr   = in_v.cpu_addr;
    assign bus[g].cpu_rnw    = in_v.cpu_rnw;
    assign bus[g].cpu_bsel   = in_v.cpu_bsel;
    assign bus[g].cpu_wrdata = in_v.cpu_wrdata;
    assign bus[g].dram_rd    = in_v.dram_rd;
    assign act[g] = {bus[g].vid_ack, bus[g].dma_ack, bus[g].cpu_ack,
                     bus[g].vid_rdstrb, bus[g].dma_rdstrb, bus[g].cpu_rdstrb,
                     bus[g].rddata, bus[g].dram_req, bus[g].dram_rnw,
                     bus[g].dram_addr, bus[g].dram_bsel, bus[g].dram_wrdata};
    dram_arb #(.RFSH_MAX(RM)) u_dut (.clk(clk), .rst(rst), .bus(bus[g]));
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] a, input logic [63:0] e);
    n_tot++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %h want %h (t=%0t)", name, a, e, $time);
  endtask

  function automatic ins_t mk(input logic vr, input logic [20:0] va,
                              input logic dr, input logic [20:0] da, input logic drw,
                              input logic [1:0] db, input logic [15:0] dw,
                              input logic cr, input logic [20:0] ca, input logic crw,
                              input logic [1:0] cb, input logic [15:0] cw,
                              input logic [15:0] rd);
    ins_t t;
    t.vid_req = vr; t.vid_addr = va;
    t.dma_req = dr; t.dma_addr = da; t.dma_rnw = drw; t.dma_bsel = db; t.dma_wrdata = dw;
    t.cpu_req = cr; t.cpu_addr = ca; t.cpu_rnw = crw; t.cpu_bsel = cb; t.cpu_wrdata = cw;
    t.dram_rd = rd;
    return t;
  endfunction

  // Slot-level reference: one call per clock edge with what was sampled there.
  task automatic model_edge(input int k, input logic r, input logic dec, input ins_t i);
    outs_t e;
    int who;
    e = exp_o[k];
    if (r) begin
      exp_o[k] = '0; cnt_m[k] = 0; last_m[k] = 3; own_m[k] = 0; gr_m[k] = 0;
      return;
    end
    {e.vid_ack, e.dma_ack, e.cpu_ack, e.vid_rdstrb, e.dma_rdstrb, e.cpu_rdstrb} = 6'b000000;
    if (dec) begin
      if (own_m[k] == 1) e.vid_rdstrb = 1'b1;
      if (own_m[k] == 2) e.dma_rdstrb = 1'b1;
      if (own_m[k] == 3) e.cpu_rdstrb = 1'b1;
      if (own_m[k] != 0) e.rddata = i.dram_rd;
      if (cnt_m[k] >= rmax_m[k])                           who = 0;
      else if (i.vid_req)                                  who = 1;
      else if (i.dma_req && (!i.cpu_req || last_m[k] == 3)) who = 2;
      else if (i.cpu_req)                                  who = 3;
      else                                                 who = 0;
      own_m[k] = 0;
      case (who)
        1: begin
          e.vid_ack = 1'b1; e.dram_req = 1'b1; e.dram_addr = i.vid_addr;
          e.dram_rnw = 1'b1; e.dram_bsel = 2'b11; own_m[k] = 1;
        end
        2: begin
          e.dma_ack = 1'b1; e.dram_req = 1'b1; e.dram_addr = i.dma_addr; e.dram_rnw = i.dma_rnw;
          e.dram_bsel = i.dma_bsel; e.dram_wrdata = i.dma_wrdata;
          own_m[k] = i.dma_rnw ? 2 : 0; last_m[k] = 2;
        end
        3: begin
          e.cpu_ack = 1'b1; e.dram_req = 1'b1; e.dram_addr = i.cpu_addr; e.dram_rnw = i.cpu_rnw;
          e.dram_bsel = i.cpu_bsel; e.dram_wrdata = i.cpu_wrdata;
          own_m[k] = i.cpu_rnw ? 3 : 0; last_m[k] = 3;
        end
        default: e.dram_req = 1'b0;
      endcase
      cnt_m[k] = (who != 0) ? cnt_m[k] + 1 : 0;
      gr_m[k]  = who;
    end
    exp_o[k] = e;
  endtask

  // One clock: capture what the edge samples, advance, compare both instances.
  task automatic tick();
    logic r_e, d_e;
    ins_t i_e;
    r_e = rst; d_e = (phase == 2'd2); i_e = in_v;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      model_edge(k, r_e, d_e, i_e);
      chk($sformatf("model_dut%0d", k), 64'(act[k]), 64'(exp_o[k]));
    end
    phase = phase + 2'd1;
  endtask

  task automatic go_c2();
    while (phase != 2'd2) tick();
  endtask

  task automatic reset_dut();
    in_v = '0;
    rst  = 1'b1;
    tick(); tick(); tick();
    rst  = 1'b0;
  endtask

  vec_t vt [8];
  int   gc [2];
  bit   pend [2][3];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{mk(1'b0,21'h0,1'b0,21'h0,1'b0,2'b00,16'h0,1'b1,21'h0ABCD,1'b1,2'b11,16'h0000,16'h0000),
              3'b001, 3'b000, 16'h0000, {1'b1,1'b1,21'h0ABCD,2'b11,16'h0000}};
    vt[1] = '{mk(1'b0,21'h0,1'b0,21'h0,1'b0,2'b00,16'h0,1'b1,21'h00100,1'b0,2'b10,16'hA55A,16'h1234),
              3'b001, 3'b001, 16'h1234, {1'b1,1'b0,21'h00100,2'b10,16'hA55A}};
    vt[2] = '{mk(1'b0,21'h0,1'b0,21'h0,1'b0,2'b00,16'h0,1'b0,21'h0,1'b0,2'b00,16'h0,16'hFFFF),
              3'b000, 3'b000, 16'h1234, {1'b0,1'b0,21'h00100,2'b10,16'hA55A}};
    vt[3] = '{mk(1'b0,21'h0,1'b1,21'h1F000,1'b1,2'b11,16'h0000,1'b1,21'h00200,1'b1,2'b11,16'h7777,16'h9999),
              3'b010, 3'b000, 16'h1234, {1'b1,1'b1,21'h1F000,2'b11,16'h0000}};
    vt[4] = '{mk(1'b0,21'h0,1'b0,21'h0,1'b0,2'b00,16'h0,1'b1,21'h00200,1'b1,2'b11,16'h7777,16'hBEEF),
              3'b001, 3'b010, 16'hBEEF, {1'b1,1'b1,21'h00200,2'b11,16'h7777}};
    vt[5] = '{mk(1'b1,21'h15555,1'b1,21'h0AAAA,1'b0,2'b01,16'h5A5A,1'b0,21'h0,1'b0,2'b00,16'h0,16'hCAFE),
              3'b100, 3'b001, 16'hCAFE, {1'b1,1'b1,21'h15555,2'b11,16'h7777}};
    vt[6] = '{mk(1'b0,21'h0,1'b1,21'h0AAAA,1'b0,2'b01,16'h5A5A,1'b0,21'h0,1'b0,2'b00,16'h0,16'h1111),
              3'b010, 3'b100, 16'h1111, {1'b1,1'b0,21'h0AAAA,2'b01,16'h5A5A}};
    vt[7] = '{mk(1'b0,21'h0,1'b0,21'h0,1'b0,2'b00,16'h0,1'b0,21'h0,1'b0,2'b00,16'h0,16'h2222),
              3'b000, 3'b000, 16'h1111, {1'b0,1'b0,21'h0AAAA,2'b01,16'h5A5A}};

    phase = 2'd0;
    for (int k = 0; k < 2; k++) begin
      exp_o[k] = '0; cnt_m[k] = 0; last_m[k] = 3; own_m[k] = 0; gr_m[k] = 0;
    end
    reset_dut();
    chk("reset_outs_dut0", 64'(act[0]), 64'(0));
    chk("reset_outs_dut1", 64'(act[1]), 64'(0));

    // directed slot table on the RFSH_MAX=31 instance
    for (int v = 0; v < 8; v++) begin
      go_c2();
      in_v = vt[v].in;
      tick();
      chk($sformatf("tbl%0d_ack", v),  64'({act[0].vid_ack, act[0].dma_ack, act[0].cpu_ack}), 64'(vt[v].ack));
      chk($sformatf("tbl%0d_strb", v), 64'({act[0].vid_rdstrb, act[0].dma_rdstrb, act[0].cpu_rdstrb}), 64'(vt[v].strb));
      chk($sformatf("tbl%0d_rdd", v),  64'(act[0].rddata), 64'(vt[v].rdd));
      chk($sformatf("tbl%0d_bus", v),  64'({act[0].dram_req, act[0].dram_rnw, act[0].dram_addr,
                                            act[0].dram_bsel, act[0].dram_wrdata}), 64'(vt[v].busv));
      tick(); tick();
      chk($sformatf("tbl%0d_wd_c0", v), 64'(act[0].dram_wrdata), 64'(vt[v].busv[15:0]));
    end

    // reset one clock after a DMA read ack
    reset_dut();
    go_c2();
    in_v.dma_req = 1'b1; in_v.dma_addr = 21'h12345; in_v.dma_rnw = 1'b1; in_v.dma_bsel = 2'b11;
    tick();
    chk("rstrd_dma_ack", 64'(act[0].dma_ack), 64'(1'b1));
    tick();
    in_v.dma_req = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstrd_outs_zero", 64'(act[0]), 64'(0));
    go_c2();
    in_v.dram_rd = 16'hDEAD;
    tick();
    chk("rstrd_no_strobe", 64'({act[0].dma_rdstrb, act[0].rddata}), 64'(0));
    go_c2();
    in_v.cpu_req = 1'b1; in_v.cpu_addr = 21'h00042; in_v.cpu_rnw = 1'b1; in_v.cpu_bsel = 2'b11;
    tick();
    chk("rstrd_cpu_ack", 64'(act[0].cpu_ack), 64'(1'b1));
    in_v.cpu_req = 1'b0;

    // contention: all three requesting continuously
    reset_dut();
    in_v = mk(1'b1,21'h0F0F0,1'b1,21'h00011,1'b1,2'b11,16'h0,1'b1,21'h00022,1'b0,2'b01,16'h3C3C,16'h4444);
    for (int s = 0; s < 40; s++) begin
      go_c2(); tick();
      chk("cont_dut1", 64'({act[1].vid_ack, act[1].dma_ack, act[1].cpu_ack}), 64'((s % 4 == 3) ? 3'b000 : 3'b100));
      chk("cont_dut0", 64'({act[0].vid_ack, act[0].dma_ack, act[0].cpu_ack}), 64'((s == 31) ? 3'b000 : 3'b100));
    end

    // round robin: DMA and CPU requesting continuously
    reset_dut();
    in_v = mk(1'b0,21'h0,1'b1,21'h00100,1'b1,2'b11,16'h0,1'b1,21'h00200,1'b1,2'b11,16'h0,16'h5555);
    gc[0] = 0; gc[1] = 0;
    for (int s = 0; s < 36; s++) begin
      go_c2(); tick();
      for (int k = 0; k < 2; k++) begin
        logic [2:0] ea;
        if (s % (rmax_m[k] + 1) == rmax_m[k]) ea = 3'b000;
        else begin
          ea = (gc[k] % 2 == 0) ? 3'b010 : 3'b001;
          gc[k]++;
        end
        chk($sformatf("rr_dut%0d_s%0d", k, s), 64'({act[k].vid_ack, act[k].dma_ack, act[k].cpu_ack}), 64'(ea));
      end
    end

    // no requests: every slot idle
    in_v = '0;
    for (int s = 0; s < 6; s++) begin
      go_c2(); tick();
      chk("noreq_dut0", 64'(act[0].dram_req), 64'(1'b0));
      chk("noreq_dut1", 64'(act[1].dram_req), 64'(1'b0));
    end

    // video only: guard starts counting from zero after idle slots
    in_v.vid_req = 1'b1; in_v.vid_addr = 21'h1ABCD;
    for (int s = 0; s < 34; s++) begin
      go_c2(); tick();
      chk("vid_dut0", 64'(act[0].vid_ack), 64'((s == 31) ? 1'b0 : 1'b1));
      chk("vid_dut1", 64'(act[1].vid_ack), 64'((s % 4 == 3) ? 1'b0 : 1'b1));
    end

    // random traffic obeying the client hold rules
    reset_dut();
    pend = '{default: 1'b0};
    for (int s = 0; s < 400; s++) begin
      go_c2();
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b1; tick(); rst = 1'b0;
        pend = '{default: 1'b0};
        go_c2();
      end
      for (int c = 0; c < 3; c++) begin
        if (!(pend[0][c] || pend[1][c])) begin
          logic r;
          r = ($urandom_range(0, 3) != 0);
          pend[0][c] = r; pend[1][c] = r;
          case (c)
            0: begin in_v.vid_req = r; in_v.vid_addr = 21'($urandom); end
            1: begin
              in_v.dma_req = r; in_v.dma_addr = 21'($urandom); in_v.dma_rnw = 1'($urandom);
              in_v.dma_bsel = 2'($urandom); in_v.dma_wrdata = 16'($urandom);
            end
            default: begin
              in_v.cpu_req = r; in_v.cpu_addr = 21'($urandom); in_v.cpu_rnw = 1'($urandom);
              in_v.cpu_bsel = 2'($urandom); in_v.cpu_wrdata = 16'($urandom);
            end
          endcase
        end
      end
      in_v.dram_rd = 16'($urandom);
      tick();
      for (int k = 0; k < 2; k++)
        if (gr_m[k] != 0) pend[k][gr_m[k] - 1] = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/dram_arb.md
# dram_arb

Three-client DRAM slot arbiter sitting directly upstream of the DRAM controller. Once per 4-phase DRAM cycle (c0..c3) it picks one client: video, DMA or CPU. It drives the controller's request, address, read/write, byte-select and write-data inputs, and captures the read word from the DRAM data pins for the client that owns the slot. Idle slots become refresh cycles in the controller, and a guard counter forces an idle slot when traffic would otherwise starve refresh.

## Interface
Parameters:
- RFSH_MAX, 31: maximum number of consecutive granted (non-idle) slots before one idle slot is forced; legal range 1..255.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- c0, c1, c2, c3  in  1 each  one-hot phase strobes, cycling c0→c1→c2→c3→c0; shared with the controller.
- vid_req  in  1  video read request (read-only client).
- vid_addr  in  21  video word address.
- vid_ack  out  1  slot granted to video.
- vid_rdstrb  out  1  `rddata` valid for video.
- dma_req, cpu_req  in  1  requests.
- dma_addr, cpu_addr  in  21  word addresses.
- dma_rnw, cpu_rnw  in  1  1 = read, 0 = write.
- dma_bsel, cpu_bsel  in  2  byte select for writes; bit0 = [7:0], bit1 = [15:8].
- dma_wrdata, cpu_wrdata  in  16  write data.
- dma_ack, cpu_ack  out  1  slot granted.
- dma_rdstrb, cpu_rdstrb  out  1  `rddata` valid for that client.
- rddata  out  16  last captured read word; shared by all clients.
- dram_rd  in  16  DRAM data pins.
- dram_req, dram_rnw  out  1  to the controller.
- dram_addr  out  21  to the controller.
- dram_bsel  out  2  to the controller.
- dram_wrdata  out  16  to the controller.

## Operation
- **Decision point.** Arbitration happens on the clock edge where `c2` is high, sampling `*_req` at that edge.
- **Priority order.**
  - Forced idle from the refresh guard wins over everything.
  - Video is next, with fixed highest priority.
  - DMA and CPU share the remaining slots round-robin. A 1-bit pointer names the preferred client and flips to the other client after every DMA or CPU grant. Reset sets the pointer to DMA.
- **On a grant:**
  - register `dram_req=1` and the granted client's addr/rnw/bsel/wrdata onto the `dram_*` outputs;
  - pulse that client's `*_ack`.
  - Video grants force `dram_rnw=1` and `dram_bsel=2'b11`; `dram_wrdata` keeps its previous value.
- **No grant** (no requests, or forced idle): `dram_req=0`. Address and data outputs hold their values; the controller performs a refresh cycle.
- **Refresh guard.**
  - The counter increments on every granted slot, saturating at RFSH_MAX, and clears on every idle slot.
  - When the counter equals RFSH_MAX at a decision point, that slot is forced idle and no `*_ack` is issued.
- **Read capture.**
  - A 2-bit "read owner" register records the client of the previous granted read slot (none for writes or idle).
  - On the `c2` edge of the following DRAM cycle, `rddata <= dram_rd` and the owner's `*_rdstrb` is pulsed.
  - The same edge makes the next arbitration decision.
- **Client rules.**
  - A client holds its request fields stable from raising `*_req` until the clock after its `*_ack`.
  - A client may then deassert or present the next access.
  - An un-acked request is never dropped.

## Timing
- `*_ack` and `*_rdstrb` are 1-clk pulses, high during the `c3` clock (registered at the `c2` edge).
- `dram_*` outputs change only at `c2` edges and are stable through the controller's `c3` latch. `dram_wrdata` remains stable through the following `c0` latch.
- **Read latency.** For a request present at the `c2` edge of slot N:
  - ack during `c3` of slot N;
  - `rddata`/`rdstrb` during `c3` of slot N+1, i.e. 4 clocks after ack.
  - `rddata` holds until the next captured read.
- **Back-to-back.** One access per 4 clocks. Video asserting continuously gets RFSH_MAX slots, then one idle slot, then resumes.
- **Simultaneous DMA+CPU with no video:** the pointer decides the grant. Continuous requests from both alternate D, C, D, C.
- **Reset** (any clock, including mid-slot):
  - all outputs 0 (`rddata=0`, `dram_req=0`, `dram_addr=0`, `dram_bsel=0`, `dram_wrdata=0`, acks and strobes 0);
  - counter 0, owner none, pointer DMA.
  - A pending read strobe is discarded.
  - While `rst` is high, no grants are made.

## Structure
- Shared package `dram_arb_pkg` holds:
  - the slot-owner enum: OWN_NONE, OWN_VID, OWN_DMA, OWN_CPU;
  - address/data width constants: 21, 16;
  - the RFSH_MAX default.
- One sub-module, `dram_rfsh_guard`: saturating consecutive-grant counter with a `force_idle` output. Inputs are the `c2` strobe and "slot granted".
- Arbitration, output mux and read capture stay in the top module.

## Test plan
- **Single CPU read.**
  - Stimulus: `cpu_req=1`, `cpu_addr=21'h0ABCD`, `rnw=1`, `dram_rd=16'h1234` at the next `c2`.
  - Response: `cpu_ack` at `c3`; `dram_addr=0ABCD`, `dram_rnw=1`; `cpu_rdstrb` 4 clocks later with `rddata=1234`.
- **CPU write.**
  - Stimulus: `cpu_rnw=0`, `bsel=2'b10`, `wrdata=16'hA55A`.
  - Response: `dram_bsel=10`, `dram_wrdata=A55A` held through the next `c0`; no `rdstrb`.
- **Contention.**
  - Stimulus: video, DMA and CPU all requesting continuously, RFSH_MAX=3.
  - Response: grant sequence V,V,V,idle,V,…; DMA and CPU never acked.
- **Round robin.**
  - Stimulus: DMA and CPU requesting continuously after reset.
  - Response: ack order D,C,D,C; idle slot after every 31 grants.
- **No requests.**
  - Stimulus: all requests low.
  - Response: `dram_req=0` every slot; counter stays 0.
- **Reset mid-read.**
  - Stimulus: `rst` pulsed one clock after `dma_ack` of a read.
  - Response: no `dma_rdstrb`, all outputs 0; a following request is acked normally.
